// File: rtl/mem_arbiter_pkg.sv
// rtl/mem_arbiter_pkg.sv - shared constants, state encoding and width helpers for mem_arbiter
//
// Purpose: client IDs, FSM state type and ceil-log2 helpers used to size
// the write/read beat counters and the ID FIFO pointers.
package mem_arbiter_pkg;

  localparam logic CLIENT_IC = 1'b0;
  localparam logic CLIENT_DC = 1'b1;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_WDATA = 1'b1
  } arb_state_e;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

  // Counter/pointer width; never zero so a 1-deep/1-beat config still has a bit.
  function automatic int cnt_bits(input int v);
    return (v > 1) ? clog2(v) : 1;
  endfunction

endpackage

// File: rtl/mem_arb_id_fifo.sv
// rtl/mem_arb_id_fifo.sv - 1-bit wide client ID FIFO for outstanding reads
//
// Purpose: records which client issued each outstanding read so response
// beats can be routed in order.
// Ports:
//   clk, reset   clock, synchronous active-low reset
//   push, push_id  enqueue one client ID
//   pop          dequeue the head ID
//   head_id      ID at the head of the queue
//   full, empty  occupancy flags
module mem_arb_id_fifo
  import mem_arbiter_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic push,
  input  logic push_id,
  input  logic pop,
  output logic head_id,
  output logic full,
  output logic empty
);

  localparam int PW = cnt_bits(DEPTH);

  logic [DEPTH-1:0] mem_q;
  logic [PW-1:0]    wr_q, wr_d;
  logic [PW-1:0]    rd_q, rd_d;
  logic [PW:0]      cnt_q, cnt_d;
  logic             do_push, do_pop;

  assign full    = (cnt_q == (PW+1)'(DEPTH));
  assign empty   = (cnt_q == '0);
  assign head_id = mem_q[rd_q];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_comb begin
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    if (do_push) wr_d = wr_q + 1'b1;
    if (do_pop)  rd_d = rd_q + 1'b1;
    // Simultaneous push and pop leaves occupancy unchanged.
    if (do_push && !do_pop) cnt_d = cnt_q + 1'b1;
    else if (do_pop && !do_push) cnt_d = cnt_q - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
      if (do_push) mem_q[wr_q] <= push_id;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - round-robin I$/D$ arbiter onto one external memory port
//
// Purpose: grants the shared request channel round-robin, holds the grant
// for a write's data beats, and routes in-order read beats via an ID FIFO.
// Ports:
//   clk, reset                     clock, synchronous active-low reset
//   ic_/dc_mem_req_*               client request and write-data channels
//   ic_/dc_mem_resp_*              client read response channel
//   mem_req_*, mem_req_data_*      external memory request/write-data channels
//   mem_resp_valid, mem_resp_data  external memory read beats
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int ADDR_BITS   = 28,
  parameter int DATA_BITS   = 128,
  parameter int DATA_CYCLES = 4,
  parameter int ID_DEPTH    = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   ic_mem_req_valid,
  output logic                   ic_mem_req_ready,
  input  logic [ADDR_BITS-1:0]   ic_mem_req_addr,
  input  logic                   ic_mem_req_rw,
  input  logic                   ic_mem_req_data_valid,
  output logic                   ic_mem_req_data_ready,
  input  logic [DATA_BITS-1:0]   ic_mem_req_data_bits,
  input  logic [DATA_BITS/8-1:0] ic_mem_req_data_mask,
  output logic                   ic_mem_resp_valid,
  output logic [DATA_BITS-1:0]   ic_mem_resp_data,
  input  logic                   dc_mem_req_valid,
  output logic                   dc_mem_req_ready,
  input  logic [ADDR_BITS-1:0]   dc_mem_req_addr,
  input  logic                   dc_mem_req_rw,
  input  logic                   dc_mem_req_data_valid,
  output logic                   dc_mem_req_data_ready,
  input  logic [DATA_BITS-1:0]   dc_mem_req_data_bits,
  input  logic [DATA_BITS/8-1:0] dc_mem_req_data_mask,
  output logic                   dc_mem_resp_valid,
  output logic [DATA_BITS-1:0]   dc_mem_resp_data,
  output logic                   mem_req_valid,
  input  logic                   mem_req_ready,
  output logic [ADDR_BITS-1:0]   mem_req_addr,
  output logic                   mem_req_rw,
  output logic                   mem_req_data_valid,
  input  logic                   mem_req_data_ready,
  output logic [DATA_BITS-1:0]   mem_req_data_bits,
  output logic [DATA_BITS/8-1:0] mem_req_data_mask,
  input  logic                   mem_resp_valid,
  input  logic [DATA_BITS-1:0]   mem_resp_data
);

  localparam int BW = cnt_bits(DATA_CYCLES);

  arb_state_e    state_q;
  logic          owner_q;
  logic          last_grant_q;
  logic [BW-1:0] wbeat_q;
  logic [BW-1:0] rbeat_q;

  logic grant, sel_valid, sel_rw;
  logic [ADDR_BITS-1:0] sel_addr;
  logic in_idle, in_wdata, rd_blocked, req_fire, data_fire;
  logic own_dvalid, wbeat_last, rbeat_last;
  logic resp_hit, head_id, fifo_full, fifo_empty;

  // On a tie the client that did not win last time gets the grant.
  always_comb begin
    if (ic_mem_req_valid && dc_mem_req_valid) grant = ~last_grant_q;
    else if (dc_mem_req_valid)                grant = CLIENT_DC;
    else                                      grant = CLIENT_IC;
  end

  assign sel_valid = (grant == CLIENT_DC) ? dc_mem_req_valid : ic_mem_req_valid;
  assign sel_addr  = (grant == CLIENT_DC) ? dc_mem_req_addr  : ic_mem_req_addr;
  assign sel_rw    = (grant == CLIENT_DC) ? dc_mem_req_rw    : ic_mem_req_rw;

  // Outputs are forced quiet while reset is held so nothing leaks out mid-reset.
  assign in_idle    = reset && (state_q == ST_IDLE);
  assign in_wdata   = reset && (state_q == ST_WDATA);
  assign rd_blocked = !sel_rw && fifo_full;

  assign mem_req_valid    = in_idle && sel_valid && !rd_blocked;
  assign mem_req_addr     = sel_addr;
  assign mem_req_rw       = sel_rw;
  assign req_fire         = mem_req_valid && mem_req_ready;
  assign ic_mem_req_ready = req_fire && (grant == CLIENT_IC);
  assign dc_mem_req_ready = req_fire && (grant == CLIENT_DC);

  assign own_dvalid            = (owner_q == CLIENT_DC) ? dc_mem_req_data_valid : ic_mem_req_data_valid;
  assign mem_req_data_valid    = in_wdata && own_dvalid;
  assign mem_req_data_bits     = (owner_q == CLIENT_DC) ? dc_mem_req_data_bits : ic_mem_req_data_bits;
  assign mem_req_data_mask     = (owner_q == CLIENT_DC) ? dc_mem_req_data_mask : ic_mem_req_data_mask;
  assign data_fire             = mem_req_data_valid && mem_req_data_ready;
  assign ic_mem_req_data_ready = data_fire && (owner_q == CLIENT_IC);
  assign dc_mem_req_data_ready = data_fire && (owner_q == CLIENT_DC);

  // Beats arriving with no outstanding read are dropped without touching rbeat.
  assign resp_hit          = reset && mem_resp_valid && !fifo_empty;
  assign ic_mem_resp_valid = resp_hit && (head_id == CLIENT_IC);
  assign dc_mem_resp_valid = resp_hit && (head_id == CLIENT_DC);
  assign ic_mem_resp_data  = mem_resp_data;
  assign dc_mem_resp_data  = mem_resp_data;

  assign wbeat_last = (wbeat_q == BW'(DATA_CYCLES - 1));
  assign rbeat_last = (rbeat_q == BW'(DATA_CYCLES - 1));

  mem_arb_id_fifo #(
    .DEPTH(ID_DEPTH)
  ) u_id_fifo (
    .clk    (clk),
    .reset  (reset),
    .push   (req_fire && !sel_rw),
    .push_id(grant),
    .pop    (resp_hit && rbeat_last),
    .head_id(head_id),
    .full   (fifo_full),
    .empty  (fifo_empty)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= ST_IDLE;
      owner_q      <= CLIENT_IC;
      last_grant_q <= CLIENT_IC;
      wbeat_q      <= '0;
      rbeat_q      <= '0;
    end else begin
      // Read beats drain independently of the request-side state.
      if (resp_hit) rbeat_q <= rbeat_last ? '0 : rbeat_q + 1'b1;
      case (state_q)
        ST_IDLE: begin
          if (req_fire) begin
            last_grant_q <= grant;
            if (sel_rw) begin
              owner_q <= grant;
              wbeat_q <= '0;
              state_q <= ST_WDATA;
            end
          end
        end
        ST_WDATA: begin
          if (data_fire) begin
            if (wbeat_last) begin
              wbeat_q <= '0;
              state_q <= ST_IDLE;
            end else begin
              wbeat_q <= wbeat_q + 1'b1;
            end
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - directed self-checking bench for mem_arbiter
module tb_mem_arbiter;

  logic          clk = 1'b0;
  logic          reset;
  logic          ic_mem_req_valid, ic_mem_req_ready, ic_mem_req_rw;
  logic [27:0]   ic_mem_req_addr;
  logic          ic_mem_req_data_valid, ic_mem_req_data_ready;
  logic [127:0]  ic_mem_req_data_bits;
  logic [15:0]   ic_mem_req_data_mask;
  logic          ic_mem_resp_valid;
  logic [127:0]  ic_mem_resp_data;
  logic          dc_mem_req_valid, dc_mem_req_ready, dc_mem_req_rw;
  logic [27:0]   dc_mem_req_addr;
  logic          dc_mem_req_data_valid, dc_mem_req_data_ready;
  logic [127:0]  dc_mem_req_data_bits;
  logic [15:0]   dc_mem_req_data_mask;
  logic          dc_mem_resp_valid;
  logic [127:0]  dc_mem_resp_data;
  logic          mem_req_valid, mem_req_ready, mem_req_rw;
  logic [27:0]   mem_req_addr;
  logic          mem_req_data_valid, mem_req_data_ready;
  logic [127:0]  mem_req_data_bits;
  logic [15:0]   mem_req_data_mask;
  logic          mem_resp_valid;
  logic [127:0]  mem_resp_data;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  mem_arbiter dut (
    .clk(clk), .reset(reset),
    .ic_mem_req_valid(ic_mem_req_valid), .ic_mem_req_ready(ic_mem_req_ready),
    .ic_mem_req_addr(ic_mem_req_addr), .ic_mem_req_rw(ic_mem_req_rw),
    .ic_mem_req_data_valid(ic_mem_req_data_valid), .ic_mem_req_data_ready(ic_mem_req_data_ready),
    .ic_mem_req_data_bits(ic_mem_req_data_bits), .ic_mem_req_data_mask(ic_mem_req_data_mask),
    .ic_mem_resp_valid(ic_mem_resp_valid), .ic_mem_resp_data(ic_mem_resp_data),
    .dc_mem_req_valid(dc_mem_req_valid), .dc_mem_req_ready(dc_mem_req_ready),
    .dc_mem_req_addr(dc_mem_req_addr), .dc_mem_req_rw(dc_mem_req_rw),
    .dc_mem_req_data_valid(dc_mem_req_data_valid), .dc_mem_req_data_ready(dc_mem_req_data_ready),
    .dc_mem_req_data_bits(dc_mem_req_data_bits), .dc_mem_req_data_mask(dc_mem_req_data_mask),
    .dc_mem_resp_valid(dc_mem_resp_valid), .dc_mem_resp_data(dc_mem_resp_data),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
    .mem_req_addr(mem_req_addr), .mem_req_rw(mem_req_rw),
    .mem_req_data_valid(mem_req_data_valid), .mem_req_data_ready(mem_req_data_ready),
    .mem_req_data_bits(mem_req_data_bits), .mem_req_data_mask(mem_req_data_mask),
    .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
    end
  endtask

  task automatic chkw(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [127:0] dpat(input int i);
    logic [31:0] w;
    w = 32'hDA7A_0000 + 32'(i);
    return {4{w}};
  endfunction

  function automatic logic [127:0] wpat(input int i);
    logic [31:0] w;
    w = 32'h5EED_0000 + 32'(i);
    return {w, ~w, w, ~w};
  endfunction

  initial begin
    logic pat [5];
    int   beat;
    pat = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1};

    reset = 1'b0;
    ic_mem_req_valid = 1'b0; ic_mem_req_addr = '0; ic_mem_req_rw = 1'b0;
    ic_mem_req_data_valid = 1'b0; ic_mem_req_data_bits = '0; ic_mem_req_data_mask = '0;
    dc_mem_req_valid = 1'b0; dc_mem_req_addr = '0; dc_mem_req_rw = 1'b0;
    dc_mem_req_data_valid = 1'b0; dc_mem_req_data_bits = '0; dc_mem_req_data_mask = '0;
    mem_req_ready = 1'b1; mem_req_data_ready = 1'b1;
    mem_resp_valid = 1'b0; mem_resp_data = '0;

    // Reset: all valid/ready outputs quiet even with memory-side readies high.
    repeat (2) tick();
    chk1("rst_mem_req_valid", mem_req_valid, 1'b0);
    chk1("rst_ic_req_ready", ic_mem_req_ready, 1'b0);
    chk1("rst_dc_req_ready", dc_mem_req_ready, 1'b0);
    chk1("rst_mem_data_valid", mem_req_data_valid, 1'b0);
    chk1("rst_ic_data_ready", ic_mem_req_data_ready, 1'b0);
    chk1("rst_dc_data_ready", dc_mem_req_data_ready, 1'b0);
    chk1("rst_ic_resp_valid", ic_mem_resp_valid, 1'b0);
    chk1("rst_dc_resp_valid", dc_mem_resp_valid, 1'b0);
    tick();

    // Single dc read, routed back to dc.
    reset = 1'b1; mem_req_data_ready = 1'b0;
    dc_mem_req_valid = 1'b1; dc_mem_req_addr = 28'h0000123; dc_mem_req_rw = 1'b0;
    #1;
    chk1("t1_mem_req_valid", mem_req_valid, 1'b1);
    chkw("t1_mem_req_addr", 128'(mem_req_addr), 128'(28'h0000123));
    chk1("t1_mem_req_rw", mem_req_rw, 1'b0);
    chk1("t1_dc_req_ready", dc_mem_req_ready, 1'b1);
    chk1("t1_ic_req_ready", ic_mem_req_ready, 1'b0);
    tick();
    dc_mem_req_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      mem_resp_valid = 1'b1; mem_resp_data = dpat(i);
      #1;
      chk1("t1_dc_resp_valid", dc_mem_resp_valid, 1'b1);
      chk1("t1_ic_resp_valid", ic_mem_resp_valid, 1'b0);
      chkw("t1_dc_resp_data", dc_mem_resp_data, dpat(i));
      tick();
    end
    mem_resp_valid = 1'b0;
    #1;
    chk1("t1_dc_resp_idle", dc_mem_resp_valid, 1'b0);

    // Tie right after reset: dc first, then ic; responses in order.
    reset = 1'b0;
    tick();
    reset = 1'b1;
    ic_mem_req_valid = 1'b1; ic_mem_req_addr = 28'h0000AAA; ic_mem_req_rw = 1'b0;
    dc_mem_req_valid = 1'b1; dc_mem_req_addr = 28'h0000BBB; dc_mem_req_rw = 1'b0;
    #1;
    chk1("t2_c0_dc_ready", dc_mem_req_ready, 1'b1);
    chk1("t2_c0_ic_ready", ic_mem_req_ready, 1'b0);
    chkw("t2_c0_addr", 128'(mem_req_addr), 128'(28'h0000BBB));
    tick();
    dc_mem_req_valid = 1'b0;
    #1;
    chk1("t2_c1_ic_ready", ic_mem_req_ready, 1'b1);
    chkw("t2_c1_addr", 128'(mem_req_addr), 128'(28'h0000AAA));
    tick();
    ic_mem_req_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      mem_resp_valid = 1'b1; mem_resp_data = dpat(16 + i);
      #1;
      chk1("t2_dc_resp_valid", dc_mem_resp_valid, i < 4);
      chk1("t2_ic_resp_valid", ic_mem_resp_valid, i >= 4);
      tick();
    end
    mem_resp_valid = 1'b0;

    // ic write with a stalling data channel while dc waits for the request channel.
    ic_mem_req_valid = 1'b1; ic_mem_req_addr = 28'h0000C00; ic_mem_req_rw = 1'b1;
    #1;
    chk1("t3_ic_req_ready", ic_mem_req_ready, 1'b1);
    chk1("t3_mem_req_rw", mem_req_rw, 1'b1);
    tick();
    ic_mem_req_valid = 1'b0; ic_mem_req_rw = 1'b0;
    ic_mem_req_data_valid = 1'b1; ic_mem_req_data_mask = 16'hA5C3;
    dc_mem_req_valid = 1'b1; dc_mem_req_addr = 28'h0000D00; dc_mem_req_rw = 1'b0;
    beat = 0;
    for (int k = 0; k < 5; k++) begin
      mem_req_data_ready = pat[k];
      ic_mem_req_data_bits = wpat(beat);
      #1;
      chk1("t3_mem_data_valid", mem_req_data_valid, 1'b1);
      chkw("t3_mem_data_bits", mem_req_data_bits, wpat(beat));
      chkw("t3_mem_data_mask", 128'(mem_req_data_mask), 128'(16'hA5C3));
      chk1("t3_ic_data_ready", ic_mem_req_data_ready, pat[k]);
      chk1("t3_dc_req_ready_wdata", dc_mem_req_ready, 1'b0);
      chk1("t3_mem_req_valid_wdata", mem_req_valid, 1'b0);
      if (pat[k]) beat++;
      tick();
    end
    ic_mem_req_data_valid = 1'b0;
    #1;
    chk1("t3_dc_req_ready_after", dc_mem_req_ready, 1'b1);
    chk1("t3_mem_data_valid_after", mem_req_data_valid, 1'b0);
    tick();
    dc_mem_req_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      mem_resp_valid = 1'b1;
      #1;
      chk1("t3_dc_resp_valid", dc_mem_resp_valid, 1'b1);
      tick();
    end
    mem_resp_valid = 1'b0;

    // Fill the ID FIFO; the fifth read waits for the first response to finish.
    dc_mem_req_valid = 1'b1; dc_mem_req_addr = 28'h0000E00; dc_mem_req_rw = 1'b0;
    for (int n = 0; n < 4; n++) begin
      #1;
      chk1("t4_fill_dc_ready", dc_mem_req_ready, 1'b1);
      tick();
    end
    #1;
    chk1("t4_full_dc_ready", dc_mem_req_ready, 1'b0);
    chk1("t4_full_mem_req_valid", mem_req_valid, 1'b0);
    tick();
    for (int i = 0; i < 4; i++) begin
      mem_resp_valid = 1'b1;
      #1;
      chk1("t4_dc_resp_valid", dc_mem_resp_valid, 1'b1);
      chk1("t4_full_during_resp", dc_mem_req_ready, 1'b0);
      tick();
    end
    mem_resp_valid = 1'b0;
    #1;
    chk1("t4_fifth_fires", dc_mem_req_ready, 1'b1);
    tick();
    dc_mem_req_valid = 1'b0;

    // Reset in the middle of a write burst.
    ic_mem_req_valid = 1'b1; ic_mem_req_addr = 28'h0000F00; ic_mem_req_rw = 1'b1;
    mem_req_data_ready = 1'b1;
    #1;
    chk1("t5_ic_req_ready", ic_mem_req_ready, 1'b1);
    tick();
    ic_mem_req_valid = 1'b0; ic_mem_req_rw = 1'b0;
    ic_mem_req_data_valid = 1'b1;
    for (int i = 0; i < 2; i++) begin
      #1;
      chk1("t5_ic_data_ready", ic_mem_req_data_ready, 1'b1);
      tick();
    end
    reset = 1'b0;
    #1;
    chk1("t5_in_reset_data_valid", mem_req_data_valid, 1'b0);
    tick();
    reset = 1'b1;
    #1;
    chk1("t5_post_rst_data_valid", mem_req_data_valid, 1'b0);
    chk1("t5_post_rst_ic_data_ready", ic_mem_req_data_ready, 1'b0);
    chk1("t5_post_rst_mem_req_valid", mem_req_valid, 1'b0);
    chk1("t5_post_rst_ic_req_ready", ic_mem_req_ready, 1'b0);
    tick();
    ic_mem_req_data_valid = 1'b0;
    mem_resp_valid = 1'b1;
    #1;
    chk1("t5_stray_ic_resp", ic_mem_resp_valid, 1'b0);
    chk1("t5_stray_dc_resp", dc_mem_resp_valid, 1'b0);
    tick();

    // Another stray beat, then a real ic read routed with a full 4-beat burst.
    #1;
    chk1("t6_stray_ic_resp", ic_mem_resp_valid, 1'b0);
    chk1("t6_stray_dc_resp", dc_mem_resp_valid, 1'b0);
    tick();
    mem_resp_valid = 1'b0;
    ic_mem_req_valid = 1'b1; ic_mem_req_addr = 28'h0000777; ic_mem_req_rw = 1'b0;
    #1;
    chk1("t6_ic_req_ready", ic_mem_req_ready, 1'b1);
    chkw("t6_addr", 128'(mem_req_addr), 128'(28'h0000777));
    tick();
    ic_mem_req_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      mem_resp_valid = 1'b1; mem_resp_data = dpat(40 + i);
      #1;
      chk1("t6_ic_resp_valid", ic_mem_resp_valid, i < 4);
      chk1("t6_dc_resp_valid", dc_mem_resp_valid, 1'b0);
      tick();
    end
    mem_resp_valid = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
